// File: rtl/cdb_arbiter_pkg.sv
// Shared core definitions for the CDB broadcast: widths, packet type and FU indices.
// Imported by the CDB arbiter, the reservation-station wakeup logic and the PRF write port.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  localparam int FU_ALU = 0;
  localparam int FU_BR  = 1;
  localparam int FU_LSU = 2;
  localparam int FU_MDU = 3;
  localparam int NUM_FU = 4;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;

  // Wraps an index that overshoots by less than n back into 0..n-1.
  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_select.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping.
// Shared by the CDB arbiter and the issue-select arbiter.
module rr_priority_select
  import cdb_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here is given a default first, so no path can infer a latch.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'(rr_wrap(int'(ptr_i) + k, N));
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry hold slot per completing unit, round-robin grant,
// registered broadcast to wakeup logic and the PRF write port.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_num_req_check
    $error("cdb_arbiter: NUM_REQ must be at least 2");
  end

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bcast_t;

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  logic [TAG_W-1:0]   slot_tag_q  [NUM_REQ];
  logic [DATA_W-1:0]  slot_data_q [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  bcast_t             cdb_q, cdb_d;
  logic [IDX_W-1:0]   cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] grant, accept;
  logic [IDX_W-1:0]   win_idx;
  logic               any_valid;

  rr_priority_select #(.N(NUM_REQ)) u_select (
    .req_i   (slot_valid_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_valid)
  );

  // A slot being drained this cycle may be refilled in the same cycle.
  assign req_ready = flush ? '0 : (~slot_valid_q | grant);
  assign accept    = req_valid & req_ready;

  always_comb begin
    slot_valid_d    = slot_valid_q;
    rr_ptr_d        = rr_ptr_q;
    cdb_d           = cdb_q;
    cdb_d.valid     = 1'b0;
    cdb_src_d       = cdb_src_q;
    if (flush) begin
      slot_valid_d = '0;
    end else begin
      if (any_valid) begin
        cdb_d     = '{valid: 1'b1, tag: slot_tag_q[win_idx], data: slot_data_q[win_idx]};
        cdb_src_d = win_idx;
        rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
      slot_valid_d = (slot_valid_q & ~grant) | accept;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_q        <= '0;
      cdb_src_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // NOTE: slot payload is deliberately not reset; slot_valid_q alone says whether it is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
        slot_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: behavioural model feeds a scoreboard of expected
// broadcasts, plus directed checks for the single-request, wrap, refill, flush and reset cases.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = NUM_FU;
  localparam int TW = CDB_TAG_W;
  localparam int DW = CDB_DATA_W;
  localparam int SW = $clog2(N);

  logic            clk, reset, flush;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } exp_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } pkt_t;

  exp_t          sb[$];
  pkt_t          unit_q[N][$];
  logic          m_v[N];
  logic [TW-1:0] m_tag[N];
  logic [DW-1:0] m_data[N];
  int            m_ptr;
  exp_t          m_last;
  logic [N-1:0]  last_ready;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = '0;
      m_data[i] = '0;
      unit_q[i].delete();
    end
    m_ptr  = 0;
    m_last = '0;
    sb.delete();
  endtask

  // One clock: drive units, check readiness against the model, predict the broadcast, compare it.
  task automatic cycle(input logic fl);
    int g;
    int j;
    logic [N-1:0] rdy;
    exp_t e;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (unit_q[i].size() > 0);
      req_tag[i*TW +: TW]  = req_valid[i] ? unit_q[i][0].tag  : '0;
      req_data[i*DW +: DW] = req_valid[i] ? unit_q[i][0].data : '0;
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (g < 0 && m_v[j]) g = j;
    end
    for (int i = 0; i < N; i++) rdy[i] = !fl && (!m_v[i] || g == i);
    last_ready = req_ready;
    check("req_ready", req_ready, rdy);
    e = m_last;
    e.v = 1'b0;
    if (fl) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    end else begin
      if (g >= 0) begin
        e.v = 1'b1;
        e.tag = m_tag[g];
        e.data = m_data[g];
        e.src = SW'(g);
        m_v[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && rdy[i]) begin
          m_v[i] = 1'b1;
          m_tag[i] = unit_q[i][0].tag;
          m_data[i] = unit_q[i][0].data;
          void'(unit_q[i].pop_front());
        end
      end
    end
    m_last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("cdb_valid", cdb_valid, e.v);
      check("cdb_tag", cdb_tag, e.tag);
      check("cdb_data", cdb_data, e.data);
      check("cdb_src", cdb_src, e.src);
    end
  endtask

  task automatic push(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
    pkt_t p;
    p.tag = t;
    p.data = d;
    unit_q[u].push_back(p);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    #3;
    reset = 1'b0;
  endtask

  int            rdy_cnt[N];
  logic [TW-1:0] refill_tags[3];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    model_reset();
    #3;
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_tag", cdb_tag, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_src", cdb_src, 0);
    check("rst_req_ready", req_ready, 4'hF);
    #5;
    reset = 1'b0;

    // Single request on unit 2.
    push(FU_LSU, 6'h15, 32'hDEADBEEF);
    cycle(1'b0);
    check("single_ready2", last_ready[FU_LSU], 1);
    check("single_not_yet", cdb_valid, 0);
    cycle(1'b0);
    check("single_valid", cdb_valid, 1);
    check("single_tag", cdb_tag, 6'h15);
    check("single_data", cdb_data, 32'hDEADBEEF);
    check("single_src", cdb_src, 2);
    cycle(1'b0);
    check("single_done", cdb_valid, 0);

    // rr_ptr is now 3: slots 1 and 3 valid -> 3 first, then wrap to 1.
    push(FU_BR, 6'h31, 32'h0000_0031);
    push(FU_MDU, 6'h33, 32'h0000_0033);
    cycle(1'b0);
    cycle(1'b0);
    check("wrap_first_src", cdb_src, 3);
    check("wrap_first_tag", cdb_tag, 6'h33);
    cycle(1'b0);
    check("wrap_second_src", cdb_src, 1);
    check("wrap_second_tag", cdb_tag, 6'h31);
    cycle(1'b0);
    check("wrap_idle", cdb_valid, 0);

    // All four units streaming from reset.
    do_reset();
    for (int u = 0; u < N; u++) begin
      rdy_cnt[u] = 0;
      for (int k = 0; k < 6; k++) push(u, TW'(u + 1), {16'(u), 16'(k)});
    end
    cycle(1'b0);
    for (int c = 1; c <= 16; c++) begin
      cycle(1'b0);
      for (int u = 0; u < N; u++) rdy_cnt[u] += int'(last_ready[u]);
      check("stream_valid", cdb_valid, 1);
      check("stream_src", cdb_src, (c - 1) % N);
      check("stream_tag", cdb_tag, (c - 1) % N + 1);
    end
    for (int u = 0; u < N; u++) check("stream_ready_pulses", rdy_cnt[u], 4);
    for (int c = 0; c < 12; c++) cycle(1'b0);
    check("stream_drained", cdb_valid, 0);

    // Same-cycle refill on unit 0: no bubbles.
    refill_tags[0] = 6'h10;
    refill_tags[1] = 6'h11;
    refill_tags[2] = 6'h12;
    for (int k = 0; k < 3; k++) push(FU_ALU, refill_tags[k], 32'h1000 + DW'(k));
    cycle(1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0);
      check("refill_valid", cdb_valid, 1);
      check("refill_tag", cdb_tag, refill_tags[k]);
    end
    cycle(1'b0);
    check("refill_idle", cdb_valid, 0);

    // Flush with slots 0 and 2 full and unit 1 requesting.
    push(FU_ALU, 6'h20, 32'h2020);
    push(FU_LSU, 6'h22, 32'h2222);
    cycle(1'b0);
    push(FU_BR, 6'h21, 32'h2121);
    cycle(1'b1);
    check("flush_ready", last_ready, 0);
    check("flush_cdb_valid", cdb_valid, 0);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0);
      check("flush_no_stale", cdb_valid && (cdb_tag == 6'h20 || cdb_tag == 6'h22), 0);
    end

    // Asynchronous reset mid-stream, between edges.
    for (int u = 0; u < N; u++)
      for (int k = 0; k < 3; k++) push(u, TW'(8 + u), 32'h5000 + DW'(u));
    for (int c = 0; c < 3; c++) cycle(1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("arst_cdb_valid", cdb_valid, 0);
    check("arst_cdb_tag", cdb_tag, 0);
    check("arst_cdb_data", cdb_data, 0);
    check("arst_cdb_src", cdb_src, 0);
    check("arst_req_ready", req_ready, 4'hF);
    model_reset();
    #2;
    reset = 1'b0;
    push(FU_BR, 6'h41, 32'h4141);
    push(FU_LSU, 6'h42, 32'h4242);
    push(FU_MDU, 6'h43, 32'h4343);
    cycle(1'b0);
    cycle(1'b0);
    check("arst_first_src", cdb_src, 1);
    check("arst_first_tag", cdb_tag, 6'h41);
    for (int c = 0; c < 3; c++) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
